// File: rtl/p08_muldiv_seq.sv
// p08_muldiv_seq: sequential unsigned shift-add multiplier / restoring divider, one bit per clock
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start_i   begin a new operation (only accepted when not busy)
//   op_i      0 = multiply, 1 = divide (sampled with start_i)
//   a_i       multiplicand / dividend (sampled with start_i)
//   b_i       multiplier / divisor (sampled with start_i)
//   busy_o    operation in progress
//   done_o    one-cycle pulse, results valid from this cycle on
//   res_hi_o  product high half / remainder
//   res_lo_o  product low half / quotient
//   dz_o      last completed divide had a zero divisor
module p08_muldiv_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             dz_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic               dz_q, dz_d;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [2*WIDTH-1:0] nxt;

    // The accumulator holds the multiplier (or dividend) in its low half; the
    // high half collects the partial product (or partial remainder).
    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, b_q};
        // diff[WIDTH] is the borrow of the trial subtraction; rem < b keeps the
        // kept difference within WIDTH bits.
        nxt    = op_q ? (diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1})
                      : {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = start_i ? RUN : IDLE;
                if (start_i) begin
                    op_d  = op_i;
                    b_d   = b_i;
                    acc_d = {{WIDTH{1'b0}}, a_i};
                    cnt_d = '0;
                end
            end
            RUN: begin
                acc_d = nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    res_hi_d = nxt[2*WIDTH-1:WIDTH];
                    res_lo_d = nxt[WIDTH-1:0];
                    dz_d     = op_q & ~|b_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = (state_q == DONE);
    assign res_hi_o = res_hi_q;
    assign res_lo_o = res_lo_q;
    assign dz_o     = dz_q;
endmodule
